// File: rtl/sr_fetch_ctrl_if.sv
// Fetch controller bus bundle: instruction-memory request/ack channel, the
// buffered instruction handed to the core decoder, and the redirect request.
//   master : the fetch controller side (drives imReq/imAddr and instr*)
//   slave  : the environment side (memory + core)
interface sr_fetch_ctrl_if;
  logic        imReq;
  logic [31:0] imAddr;
  logic        imAck;
  logic [31:0] imData;
  logic [31:0] instr;
  logic [31:0] instrPc;
  logic        instrValid;
  logic        instrReady;
  logic        redirect;
  logic [31:0] redirectPc;

  modport master (
    output imReq, imAddr, instr, instrPc, instrValid,
    input  imAck, imData, instrReady, redirect, redirectPc
  );

  modport slave (
    input  imReq, imAddr, instr, instrPc, instrValid,
    output imAck, imData, instrReady, redirect, redirectPc
  );
endinterface

// File: rtl/sr_fetch_ctrl.sv
// Single-entry instruction fetch controller.
// Keeps a fetch pointer, issues one memory request at a time, buffers the
// returned word for the core and handles branch redirects, including one that
// arrives while a request is still outstanding (the stale word is dropped).
// Ports:
//   clk  : clock, all state changes on the rising edge
//   rst  : asynchronous active-high reset
//   bus  : sr_fetch_ctrl_if.master (memory channel, core channel, redirect)
module sr_fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst,
  sr_fetch_ctrl_if.master   bus
);

  localparam logic [31:0] Nop = 32'h0000_0013;

  typedef enum logic [1:0] {StFetch, StHold, StDrop} state_e;

  state_e      state;
  logic [31:0] fpc;
  logic [31:0] addr;
  logic        req;
  logic [31:0] instr_q;
  logic [31:0] pc_q;
  logic        valid;

  logic [31:0] target;
  logic [31:0] fpc_inc;

  assign target  = {bus.redirectPc[31:2], 2'b00};
  assign fpc_inc = fpc + 32'd4;  // wraps naturally modulo 2^32

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= StFetch;
      fpc     <= RESET_PC;
      addr    <= RESET_PC;
      req     <= 1'b0;
      instr_q <= Nop;
      pc_q    <= RESET_PC;
      valid   <= 1'b0;
    end else begin
      unique case (state)
        StFetch: begin
          if (!req) begin
            // First cycle after reset: nothing outstanding, so acks are ignored
            // and a redirect simply retargets the first request.
            req <= 1'b1;
            if (bus.redirect) begin
              fpc  <= target;
              addr <= target;
            end
          end else if (bus.redirect && bus.imAck) begin
            // Request completes together with the redirect: drop the word and
            // launch the next request straight at the target.
            fpc  <= target;
            addr <= target;
          end else if (bus.redirect) begin
            // Request still in flight: keep it stable and drain it in DROP.
            fpc   <= target;
            state <= StDrop;
          end else if (bus.imAck) begin
            instr_q <= bus.imData;
            pc_q    <= fpc;
            valid   <= 1'b1;
            fpc     <= fpc_inc;
            req     <= 1'b0;
            state   <= StHold;
          end
        end
        StHold: begin
          // Redirect wins over consumption; the buffered word is discarded.
          if (bus.redirect) begin
            fpc   <= target;
            addr  <= target;
            valid <= 1'b0;
            req   <= 1'b1;
            state <= StFetch;
          end else if (bus.instrReady) begin
            addr  <= fpc;
            valid <= 1'b0;
            req   <= 1'b1;
            state <= StFetch;
          end
        end
        StDrop: begin
          if (bus.imAck) begin
            fpc   <= bus.redirect ? target : fpc;
            addr  <= bus.redirect ? target : fpc;
            state <= StFetch;
          end else if (bus.redirect) begin
            fpc <= target;
          end
        end
        default: state <= StFetch;
      endcase
    end
  end

  assign bus.imReq      = req;
  assign bus.imAddr     = addr;
  assign bus.instr      = instr_q;
  assign bus.instrPc    = pc_q;
  assign bus.instrValid = valid;

endmodule

// File: tb/tb_sr_fetch_ctrl.sv
// Directed bench for sr_fetch_ctrl: sequential fetch, stall, redirects in
// every state, pointer wrap and mid-transaction reset.
module tb_sr_fetch_ctrl;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;

  sr_fetch_ctrl_if bus ();

  sr_fetch_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Request must be up at addr; memory acks in its second cycle; word lands next cycle.
  task automatic serve(input logic [31:0] a, input logic [31:0] d);
    chk("req_up", {31'd0, bus.imReq}, 32'd1);
    chk("req_addr", bus.imAddr, a);
    chk("fetch_invalid", {31'd0, bus.instrValid}, 32'd0);
    tick();
    chk("req_hold", {31'd0, bus.imReq}, 32'd1);
    chk("addr_stable", bus.imAddr, a);
    bus.imAck  = 1'b1;
    bus.imData = d;
    tick();
    bus.imAck  = 1'b0;
    chk("valid_n1", {31'd0, bus.instrValid}, 32'd1);
    chk("instr", bus.instr, d);
    chk("instr_pc", bus.instrPc, a);
    chk("req_low_hold", {31'd0, bus.imReq}, 32'd0);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst             = 1'b1;
    bus.imAck       = 1'b0;
    bus.imData      = 32'd0;
    bus.instrReady  = 1'b1;
    bus.redirect    = 1'b0;
    bus.redirectPc  = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req", {31'd0, bus.imReq}, 32'd0);
    chk("rst_addr", bus.imAddr, 32'h0);
    chk("rst_instr", bus.instr, 32'h0000_0013);
    chk("rst_pc", bus.instrPc, 32'h0);
    chk("rst_valid", {31'd0, bus.instrValid}, 32'd0);

    // Release; a stray ack with imReq=0 must be ignored.
    rst        = 1'b0;
    bus.imAck  = 1'b1;
    bus.imData = 32'hDEAD_DEAD;
    tick();
    bus.imAck = 1'b0;
    chk("rel_req", {31'd0, bus.imReq}, 32'd1);
    chk("rel_addr", bus.imAddr, 32'h0);
    chk("rel_valid", {31'd0, bus.instrValid}, 32'd0);

    // Sequential stream 0,4,8,12 with one bubble after each word.
    for (int k = 0; k < 4; k++) begin
      serve(32'(k * 4), 32'h1000_0000 + 32'(k));
      tick();
      chk("bubble", {31'd0, bus.instrValid}, 32'd0);
    end

    // Stall in HOLD for 5 cycles; stray ack in the middle is ignored.
    bus.instrReady = 1'b0;
    serve(32'h10, 32'h2000_0010);
    for (int i = 0; i < 5; i++) begin
      if (i == 2) begin
        bus.imAck  = 1'b1;
        bus.imData = 32'hFFFF_FFFF;
      end
      tick();
      bus.imAck = 1'b0;
      chk("stall_instr", bus.instr, 32'h2000_0010);
      chk("stall_pc", bus.instrPc, 32'h10);
      chk("stall_valid", {31'd0, bus.instrValid}, 32'd1);
      chk("stall_req", {31'd0, bus.imReq}, 32'd0);
    end
    bus.instrReady = 1'b1;
    tick();
    chk("consume_valid", {31'd0, bus.instrValid}, 32'd0);
    chk("consume_req", {31'd0, bus.imReq}, 32'd1);
    chk("consume_addr", bus.imAddr, 32'h14);

    // Redirect in HOLD with instrReady=1: word discarded, fetch at target.
    serve(32'h14, 32'h3000_0014);
    bus.redirect   = 1'b1;
    bus.redirectPc = 32'h8;
    tick();
    bus.redirect = 1'b0;
    chk("hold_redir_valid", {31'd0, bus.instrValid}, 32'd0);
    chk("hold_redir_req", {31'd0, bus.imReq}, 32'd1);
    chk("hold_redir_addr", bus.imAddr, 32'h8);

    // Redirect to 0x103 while request to 8 is outstanding -> DROP.
    bus.redirect   = 1'b1;
    bus.redirectPc = 32'h0000_0103;
    tick();
    bus.redirect = 1'b0;
    chk("drop_req", {31'd0, bus.imReq}, 32'd1);
    chk("drop_addr", bus.imAddr, 32'h8);
    chk("drop_valid", {31'd0, bus.instrValid}, 32'd0);
    tick();
    chk("drop_addr2", bus.imAddr, 32'h8);
    bus.imAck  = 1'b1;
    bus.imData = 32'hBAD0_0008;
    tick();
    bus.imAck = 1'b0;
    chk("drop_discard", {31'd0, bus.instrValid}, 32'd0);
    chk("drop_next_req", {31'd0, bus.imReq}, 32'd1);
    chk("drop_next_addr", bus.imAddr, 32'h0000_0100);

    // Redirect in the same cycle as imAck; low bits of target are ignored.
    tick();
    bus.imAck      = 1'b1;
    bus.imData     = 32'hBAD0_0100;
    bus.redirect   = 1'b1;
    bus.redirectPc = 32'hFFFF_FFFE;
    tick();
    bus.imAck    = 1'b0;
    bus.redirect = 1'b0;
    chk("same_valid", {31'd0, bus.instrValid}, 32'd0);
    chk("same_req", {31'd0, bus.imReq}, 32'd1);
    chk("same_addr", bus.imAddr, 32'hFFFF_FFFC);

    // Pointer wrap.
    serve(32'hFFFF_FFFC, 32'h4000_FFFC);
    tick();
    chk("wrap_addr", bus.imAddr, 32'h0);
    serve(32'h0, 32'h5000_0000);
    tick();
    chk("pre_rst_addr", bus.imAddr, 32'h4);
    tick();

    // Reset mid-FETCH: outputs drop immediately.
    rst = 1'b1;
    #1;
    chk("mid_rst_req", {31'd0, bus.imReq}, 32'd0);
    chk("mid_rst_valid", {31'd0, bus.instrValid}, 32'd0);
    chk("mid_rst_addr", bus.imAddr, 32'h0);
    chk("mid_rst_instr", bus.instr, 32'h0000_0013);
    @(posedge clk);
    #1;
    rst = 1'b0;
    tick();
    serve(32'h0, 32'h6000_0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
